usb_cmd_frame_parser: RTL and testbench

Parametrised receive-side framer for the USB command channel. It consumes the raw USB byte stream and recognises frames of the form AA 55 cmd len_hi len_lo payload[len] checksum status. It reports each command header, streams the payload to the selected handler (I2C, PWM, UART, DAC), and flags the frame as good or bad on completion. It replaces the fixed-length in-line parsing with configurable payload limit, checksum mode and inter-byte timeout.

---
 rtl/usb_cmd_frame_parser.sv | 184 ++++++++++++++++++
 tb/tb_usb_cmd_frame_parser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_frame_parser.sv
// Receive-side framer for the USB command channel: AA 55 cmd len_hi len_lo payload[len] checksum status.
// Reports the header, streams payload bytes and flags good/bad completion, one cycle after each byte.
module usb_cmd_frame_parser #(
  parameter int unsigned MAX_PAYLOAD    = 256,
  parameter int unsigned CKSUM_MODE     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic [7:0]  cmd_out,
  output logic [15:0] cmd_len,
  output logic        cmd_start,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        cmd_done,
  output logic        cmd_error,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC2   = 3'd1,
    ST_CMD     = 3'd2,
    ST_LEN_H   = 3'd3,
    ST_LEN_L   = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CKSUM   = 3'd6,
    ST_STATUS  = 3'd7
  } state_t;

  localparam logic [7:0]  SYNC_A      = 8'hAA;
  localparam logic [7:0]  SYNC_B      = 8'h55;
  localparam logic [1:0]  ERR_CKSUM   = 2'd1;
  localparam logic [1:0]  ERR_LEN     = 2'd2;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd3;
  localparam logic [16:0] MAX_LEN     = 17'(MAX_PAYLOAD);
  localparam bit          TMO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST    = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] b);
    if (CKSUM_MODE == 1) return acc ^ b;
    else                 return acc + b;
  endfunction

  state_t      state_r;
  logic [7:0]  acc_r;
  logic [7:0]  cmd_r;
  logic [7:0]  len_hi_r;
  logic [15:0] remaining_r;
  logic        cksum_ok_r;
  logic [31:0] tmo_cnt_r;
  logic [15:0] len_s;

  assign len_s = {len_hi_r, usb_data_in};

  // Frame FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      acc_r         <= 8'h00;
      cmd_r         <= 8'h00;
      len_hi_r      <= 8'h00;
      remaining_r   <= 16'd0;
      cksum_ok_r    <= 1'b0;
      tmo_cnt_r     <= 32'd0;
      cmd_out       <= 8'h00;
      cmd_len       <= 16'd0;
      cmd_start     <= 1'b0;
      payload_data  <= 8'h00;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_error     <= 1'b0;
      err_code      <= 2'd0;
      busy          <= 1'b0;
    end else begin
      cmd_start     <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_error     <= 1'b0;
      if (usb_data_valid_in) begin
        tmo_cnt_r <= 32'd0;
        case (state_r)
          ST_IDLE: begin
            if (usb_data_in == SYNC_A) begin
              state_r <= ST_SYNC2;
              busy    <= 1'b1;
              acc_r   <= cksum_step(8'h00, usb_data_in);
            end else begin
              acc_r   <= 8'h00;
            end
          end
          ST_SYNC2: begin
            if (usb_data_in == SYNC_B) begin
              state_r <= ST_CMD;
              acc_r   <= cksum_step(acc_r, usb_data_in);
            end else if (usb_data_in == SYNC_A) begin
              // A repeated AA restarts the frame, so the sum restarts too.
              acc_r   <= cksum_step(8'h00, usb_data_in);
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              acc_r   <= 8'h00;
            end
          end
          ST_CMD: begin
            cmd_r   <= usb_data_in;
            acc_r   <= cksum_step(acc_r, usb_data_in);
            state_r <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_hi_r <= usb_data_in;
            acc_r    <= cksum_step(acc_r, usb_data_in);
            state_r  <= ST_LEN_L;
          end
          ST_LEN_L: begin
            acc_r <= cksum_step(acc_r, usb_data_in);
            if ({1'b0, len_s} > MAX_LEN) begin
              cmd_error <= 1'b1;
              err_code  <= ERR_LEN;
              state_r   <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              cmd_out     <= cmd_r;
              cmd_len     <= len_s;
              cmd_start   <= 1'b1;
              remaining_r <= len_s;
              state_r     <= (len_s == 16'd0) ? ST_CKSUM : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            payload_data  <= usb_data_in;
            payload_valid <= 1'b1;
            payload_last  <= (remaining_r == 16'd1);
            remaining_r   <= remaining_r - 16'd1;
            acc_r         <= cksum_step(acc_r, usb_data_in);
            if (remaining_r == 16'd1) begin
              state_r <= ST_CKSUM;
            end else begin
              state_r <= ST_PAYLOAD;
            end
          end
          ST_CKSUM: begin
            cksum_ok_r <= (usb_data_in == acc_r);
            state_r    <= ST_STATUS;
          end
          ST_STATUS: begin
            if (cksum_ok_r) begin
              cmd_done  <= 1'b1;
            end else begin
              cmd_error <= 1'b1;
              err_code  <= ERR_CKSUM;
            end
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else if (TMO_EN && (state_r != ST_IDLE)) begin
        if (tmo_cnt_r == TMO_LAST) begin
          cmd_error <= 1'b1;
          err_code  <= ERR_TIMEOUT;
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          tmo_cnt_r <= 32'd0;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
      end else begin
        tmo_cnt_r <= 32'd0;
        if (state_r == ST_IDLE) acc_r <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Bench for usb_cmd_frame_parser: instance 0 uses additive checksum, instance 1 XOR; both limit payload to 16
// bytes and time out after 50 idle cycles. Frames are checked per byte against a list-level frame model.
module tb_usb_cmd_frame_parser;

  localparam int MAXP = 16;
  localparam int TMO  = 50;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       dv;

  logic [7:0]  o_cmd [2];
  logic [15:0] o_len [2];
  logic        o_start [2];
  logic [7:0]  o_pdata [2];
  logic        o_pv [2];
  logic        o_last [2];
  logic        o_done [2];
  logic        o_err [2];
  logic [1:0]  o_code [2];
  logic        o_busy [2];

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;

  always #5 clk = ~clk;

  usb_cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .CKSUM_MODE(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .usb_data_in(din), .usb_data_valid_in(dv),
    .cmd_out(o_cmd[0]), .cmd_len(o_len[0]), .cmd_start(o_start[0]),
    .payload_data(o_pdata[0]), .payload_valid(o_pv[0]), .payload_last(o_last[0]),
    .cmd_done(o_done[0]), .cmd_error(o_err[0]), .err_code(o_code[0]), .busy(o_busy[0]));

  usb_cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .CKSUM_MODE(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .usb_data_in(din), .usb_data_valid_in(dv),
    .cmd_out(o_cmd[1]), .cmd_len(o_len[1]), .cmd_start(o_start[1]),
    .payload_data(o_pdata[1]), .payload_valid(o_pv[1]), .payload_last(o_last[1]),
    .cmd_done(o_done[1]), .cmd_error(o_err[1]), .err_code(o_code[1]), .busy(o_busy[1]));

  function automatic logic [39:0] all_out(input int k);
    return {o_cmd[k], o_len[k], o_start[k], o_pdata[k], o_pv[k], o_last[k],
            o_done[k], o_err[k], o_code[k], o_busy[k]};
  endfunction

  function automatic logic [4:0] events(input int k);
    return {o_start[k], o_pv[k], o_last[k], o_done[k], o_err[k]};
  endfunction

  // Reference checksum: plain arithmetic over b[from..to].
  function automatic logic [7:0] model_sum(input bq_t b, input int from, input int to, input int mode);
    int acc = 0;
    for (int i = from; i <= to; i++) begin
      if (mode == 1) acc = acc ^ int'(b[i]);
      else           acc = (acc + int'(b[i])) % 256;
    end
    return acc[7:0];
  endfunction

  task automatic drive(input logic [7:0] d, input logic v);
    din = d;
    dv  = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives a byte list (one frame, optionally preceded by junk) and checks every response cycle.
  task automatic check_frame(input string name, input bq_t b, input int k, input int tail);
    int s, len, ck_i, st_i, code;
    logic over, good;
    logic e_start, e_pv, e_last, e_done, e_err;
    sel = k;
    s = -1;
    for (int i = 0; i + 1 < b.size(); i++)
      if (s < 0 && b[i] == 8'hAA && b[i+1] == 8'h55) s = i;
    len  = int'(b[s+3]) * 256 + int'(b[s+4]);
    over = (len > MAXP);
    ck_i = s + 5 + len;
    st_i = ck_i + 1;
    good = !over && (ck_i < b.size()) && (b[ck_i] == model_sum(b, s, ck_i - 1, k));
    code = over ? 2 : 1;
    for (int i = 0; i < b.size(); i++) begin
      drive(b[i], 1'b1);
      e_start = !over && (i == s + 4);
      e_pv    = !over && (i >= s + 5) && (i < ck_i);
      e_last  = e_pv && (i == ck_i - 1);
      e_done  = !over && (i == st_i) && good;
      e_err   = over ? (i == s + 4) : ((i == st_i) && !good);
      n_checks++;
      if (events(k) !== {e_start, e_pv, e_last, e_done, e_err})
        $display("FAIL %s events@byte%0d: got %b want %b", name, i, events(k), {e_start, e_pv, e_last, e_done, e_err});
      else n_pass++;
      if (e_start) begin
        n_checks++;
        if ({o_cmd[k], o_len[k]} !== {b[s+2], 16'(len)})
          $display("FAIL %s header: got cmd %h len %0d want cmd %h len %0d", name, o_cmd[k], o_len[k], b[s+2], len);
        else n_pass++;
      end
      if (e_pv) begin
        n_checks++;
        if (o_pdata[k] !== b[i])
          $display("FAIL %s payload@byte%0d: got %h want %h", name, i, o_pdata[k], b[i]);
        else n_pass++;
      end
      if (e_err) begin
        n_checks++;
        if (o_code[k] !== 2'(code))
          $display("FAIL %s err_code: got %0d want %0d", name, o_code[k], code);
        else n_pass++;
      end
    end
    n_checks++;
    if (o_busy[k] !== 1'b0) $display("FAIL %s busy_end: got %b want 0", name, o_busy[k]);
    else n_pass++;
    for (int t = 0; t < tail; t++) begin
      drive(8'h00, 1'b0);
      n_checks++;
      if (events(k) !== 5'b0) $display("FAIL %s idle_tail: got %b want 00000", name, events(k));
      else n_pass++;
    end
  endtask

  function automatic bq_t gen_frame(input int mode);
    bq_t f;
    int len;
    logic [7:0] ck;
    len = $urandom_range(0, 20);
    f = {8'hAA, 8'h55, 8'($urandom_range(0, 255)), 8'(len / 256), 8'(len % 256)};
    if (len <= MAXP) begin
      for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
      ck = model_sum(f, 0, f.size() - 1, mode);
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      f.push_back(ck);
      f.push_back(8'($urandom_range(0, 255)));
    end
    return f;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (all_out(k) !== 40'd0) $display("FAIL reset_state dut%0d: got %h want 0", k, all_out(k));
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    check_frame("basic", {8'hAA, 8'h55, 8'h04, 8'h00, 8'h05, 8'h00, 8'h01, 8'h86, 8'hA0, 8'h50, 8'h7F, 8'h00}, 0, 2);
    n_checks++;
    if (o_code[0] !== 2'd0) $display("FAIL basic err_code_held: got %0d want 0", o_code[0]);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    check_frame("zero_len", {8'hAA, 8'h55, 8'h07, 8'h00, 8'h00, 8'h06, 8'h00}, 0, 2);
  endtask

  task automatic test_bad_cksum();
    check_frame("bad_cksum", {8'hAA, 8'h55, 8'h04, 8'h00, 8'h05, 8'h00, 8'h01, 8'h86, 8'hA0, 8'h50, 8'h7E, 8'h00}, 0, 2);
  endtask

  task automatic test_overflow();
    bq_t f;
    check_frame("overflow", {8'hAA, 8'h55, 8'h05, 8'h00, 8'h20}, 0, 1);
    n_checks++;
    if (o_code[0] !== 2'd2) $display("FAIL overflow err_code_held: got %0d want 2", o_code[0]);
    else n_pass++;
    f = {8'hAA, 8'h55, 8'h05, 8'h00, 8'h10};
    for (int i = 0; i < 16; i++) f.push_back(8'(i * 7));
    f.push_back(model_sum(f, 0, f.size() - 1, 0));
    f.push_back(8'h00);
    check_frame("after_overflow_max", f, 0, 1);
  endtask

  task automatic test_resync();
    bq_t f;
    f = {8'h12, 8'hAA, 8'hAA, 8'h55, 8'h05, 8'h00, 8'h02, 8'h10, 8'hDE};
    f.push_back(model_sum(f, 2, f.size() - 1, 0));
    f.push_back(8'h00);
    check_frame("resync", f, 0, 1);
  endtask

  task automatic test_timeout();
    bq_t f;
    sel = 0;
    drive(8'hAA, 1'b1); drive(8'h55, 1'b1); drive(8'h05, 1'b1);
    for (int c = 1; c <= TMO; c++) begin
      drive(8'h00, 1'b0);
      n_checks++;
      if (o_err[0] !== (c == TMO)) $display("FAIL timeout idle%0d: got err %b want %b", c, o_err[0], (c == TMO));
      else n_pass++;
    end
    n_checks++;
    if ({o_code[0], o_busy[0]} !== {2'd3, 1'b0}) $display("FAIL timeout code_busy: got %b want 110", {o_code[0], o_busy[0]});
    else n_pass++;
    // A byte arriving exactly when the count would expire keeps the frame alive.
    drive(8'hAA, 1'b1); drive(8'h55, 1'b1); drive(8'h05, 1'b1);
    for (int c = 1; c < TMO; c++) drive(8'h00, 1'b0);
    f = {8'hAA, 8'h55, 8'h05, 8'h00, 8'h01, 8'h33};
    drive(8'h00, 1'b1);
    n_checks++;
    if ({o_err[0], o_busy[0]} !== 2'b01) $display("FAIL byte_wins: got err,busy %b want 01", {o_err[0], o_busy[0]});
    else n_pass++;
    drive(8'h01, 1'b1);
    drive(8'h33, 1'b1);
    n_checks++;
    if ({o_start[0], o_pv[0], o_last[0], o_pdata[0]} !== {3'b011, 8'h33}) $display("FAIL byte_wins payload: got %b want 01100110011", {o_start[0], o_pv[0], o_last[0], o_pdata[0]});
    else n_pass++;
    drive(model_sum(f, 0, 5, 0), 1'b1);
    drive(8'h00, 1'b1);
    n_checks++;
    if ({o_done[0], o_err[0]} !== 2'b10) $display("FAIL byte_wins done: got done,err %b want 10", {o_done[0], o_err[0]});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bq_t f;
    drive(8'hAA, 1'b1); drive(8'h55, 1'b1); drive(8'h03, 1'b1); drive(8'h00, 1'b1); drive(8'h0A, 1'b1);
    for (int i = 0; i < 3; i++) drive(8'(8'h20 + i), 1'b1);
    rst_n = 1'b0;
    drive(8'h23, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (all_out(k) !== 40'd0) $display("FAIL reset_mid dut%0d: got %h want 0", k, all_out(k));
      else n_pass++;
    end
    drive(8'h00, 1'b0);
    f = {8'hAA, 8'h55, 8'h09, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    f.push_back(model_sum(f, 0, f.size() - 1, 0));
    f.push_back(8'h5A);
    check_frame("after_reset", f, 0, 1);
  endtask

  task automatic test_xor();
    bq_t f;
    f = {8'hAA, 8'h55, 8'h04, 8'h00, 8'h05, 8'h00, 8'h01, 8'h86, 8'hA0, 8'h50};
    f.push_back(model_sum(f, 0, f.size() - 1, 1));
    f.push_back(8'h00);
    check_frame("xor_mode", f, 1, 2);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) check_frame("random_b2b", gen_frame(n % 2), n % 2, 0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    dv    = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_zero_len();
    test_bad_cksum();
    test_overflow();
    test_resync();
    test_timeout();
    test_reset_mid();
    test_xor();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
